// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, fetch state encoding and queue entry type
package if_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h4000_0000;
  typedef enum logic {FS_BOOT = 1'b0, FS_RUN = 1'b1} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory, redirect and decode-handshake bundle
//   imem_en/imem_addr/imem_dout : synchronous imem read port (1-cycle latency)
//   redirect_valid/redirect_pc  : PC redirect from execute
//   out_valid/out_ready/out_inst/out_pc : fetched instruction stream to decode
//   master = fetch unit side, slave = environment side
interface if_fetch_unit_if #(parameter int IMEM_AW = 14);
  import if_fetch_unit_pkg::*;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_dout;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_inst;
  logic [XLEN-1:0]    out_pc;
  modport master (
    output imem_en, imem_addr, out_valid, out_inst, out_pc,
    input  imem_dout, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_en, imem_addr, out_valid, out_inst, out_pc,
    output imem_dout, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry FIFO of {inst,pc} with write, pop and synchronous flush
//   clk, rst_n     : clock, async active-low reset
//   flush          : empty the queue (wins over wr/pop)
//   wr/wdata       : enqueue an entry
//   pop            : dequeue the head
//   head           : current head entry (holds reset entry until first write)
//   count/full/empty : occupancy
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, slot;
  logic wr_ok, pop_ok;
  assign wr_ok = wr & ~flush;
  assign pop_ok = pop & ~flush;
  // slot the incoming entry lands in after this cycle's pop shifts the queue
  assign slot = cnt_q - {1'b0, pop_ok};
  always_comb begin
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, wr_ok} - {1'b0, pop_ok};
    e0_d = (pop_ok && cnt_q == 2'd2) ? e1_q : ((wr_ok && slot == 2'd0) ? wdata : e0_q);
    e1_d = (wr_ok && slot == 2'd1) ? wdata : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q <= '{inst: INST_NOP, pc: RESET_PC};
      e1_q <= '{inst: INST_NOP, pc: RESET_PC};
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign head = e0_q;
  assign count = cnt_q;
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end (PC, imem issue, 2-entry queue, redirect)
//   clk, rst_n : clock, async active-low reset
//   bus        : if_fetch_unit_if.master (imem port, redirect, decode handshake)
//   perf_fetch_cnt/perf_redirect_cnt/perf_stall_cnt : present only with FETCH_PERF_EN
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int IMEM_AW = 14,
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  if_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_redirect_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, ipc_q, ipc_d, rpc, fetch_pc;
  logic inflight_q, inflight_d;
  logic run, redir, pop, issue, wr;
  logic [1:0] count;
  logic q_full, q_empty, unused_q_full;
  fetch_entry_t head;
  assign run = state_q == FS_RUN;
  assign redir = bus.redirect_valid & run;
  assign rpc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign pop = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
  // queued + in-flight after this cycle's pop must leave room for one more word
  assign issue = run & (redir | (({1'b0, count} + {2'b0, inflight_q}) < (3'(BUF_DEPTH) + {2'b0, pop})));
  assign fetch_pc = redir ? rpc : pc_q;
  // a redirect kills the response landing this cycle
  assign wr = inflight_q & ~redir;
  always_comb begin
    state_d = FS_RUN;
    pc_d = issue ? fetch_pc + 32'd4 : ((!run && bus.redirect_valid) ? rpc : pc_q);
    ipc_d = issue ? fetch_pc : ipc_q;
    inflight_d = issue;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_BOOT;
      pc_q <= RESET_PC;
      ipc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ipc_q <= ipc_d;
      inflight_q <= inflight_d;
    end
  end
  fetch_queue #(.RESET_PC(RESET_PC)) u_q (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redir),
    .wr(wr),
    .wdata('{inst: bus.imem_dout, pc: ipc_q}),
    .pop(pop),
    .head(head),
    .count(count),
    .full(q_full),
    .empty(q_empty)
  );
  assign unused_q_full = q_full;
  assign bus.imem_en = issue;
  assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];
  assign bus.out_valid = ~q_empty;
  assign bus.out_inst = head.inst;
  assign bus.out_pc = head.pc;
`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] pf_q, pf_d, pr_q, pr_d, ps_q, ps_d;
  always_comb begin
    pf_d = pf_q + {31'd0, pop};
    pr_d = pr_q + {31'd0, redir};
    ps_d = ps_q + {31'd0, bus.out_valid & ~bus.out_ready};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q <= '0;
      pr_q <= '0;
      ps_q <= '0;
    end else begin
      pf_q <= pf_d;
      pr_q <= pr_d;
      ps_q <= ps_d;
    end
  end
  assign perf_fetch_cnt = pf_q;
  assign perf_redirect_cnt = pr_q;
  assign perf_stall_cnt = ps_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized self-checking bench with a stream-level reference model
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  localparam logic [31:0] RPC = 32'h4000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  if_fetch_unit_if #(.IMEM_AW(14)) bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt;
`endif
  if_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_redirect_cnt(perf_redirect_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  int total = 0;
  int bad = 0;
  logic [31:0] salt = 32'h0;
  function automatic logic [31:0] mem_fn(input logic [13:0] a);
    return {16'h0, a, 2'b00} ^ salt;
  endfunction
  logic [13:0] rd_addr = '0;
  always @(posedge clk) if (bus.imem_en) rd_addr <= bus.imem_addr;
  assign bus.imem_dout = mem_fn(rd_addr);
  logic [31:0] exp_pc, last_acc, prev_pc, prev_inst;
  logic [13:0] last_issue;
  logic boot, hold;
  int m_pops, m_redir, m_stall;
  task model_reset(input logic in_boot);
    exp_pc = RPC;
    last_acc = RPC - 32'd4;
    boot = in_boot;
    hold = 1'b0;
    m_pops = 0;
    m_redir = 0;
    m_stall = 0;
  endtask
  // Evaluate one cycle from the stream-level view, then advance to the next negedge.
  task step();
    #1;
    if (hold) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== prev_pc || bus.out_inst !== prev_inst) begin
        bad++;
        $display("FAIL hold_stable: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 bus.out_valid, bus.out_pc, bus.out_inst, prev_pc, prev_inst);
      end
    end
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      total++;
      if (bus.out_pc !== exp_pc || bus.out_inst !== mem_fn(exp_pc[15:2])) begin
        bad++;
        $display("FAIL pop_data: got pc=%h inst=%h want pc=%h inst=%h",
                 bus.out_pc, bus.out_inst, exp_pc, mem_fn(exp_pc[15:2]));
      end
      last_acc = exp_pc;
      exp_pc = exp_pc + 32'd4;
      m_pops++;
    end
    if (bus.redirect_valid) begin
      exp_pc = {bus.redirect_pc[31:2], 2'b00};
      if (!boot) m_redir++;
    end
    if (bus.out_valid && !bus.out_ready) m_stall++;
    if (bus.imem_en) last_issue = bus.imem_addr;
    total++;
    if (dut.u_q.full && dut.u_q.wr) begin
      bad++;
      $display("FAIL full_write: got full=1 wr=1 want not both");
    end
    hold = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
    prev_pc = bus.out_pc;
    prev_inst = bus.out_inst;
    boot = 1'b0;
    @(negedge clk);
  endtask
  task stream(input int n);
    int v;
    v = 0;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.out_valid) v++;
      step();
    end
    total++;
    if (v !== n) begin
      bad++;
      $display("FAIL throughput: got %0d valid cycles want %0d", v, n);
    end
  endtask
  task test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.out_inst !== 32'h0000_0013 || bus.out_pc !== RPC) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b en=%b inst=%h pc=%h want v=0 en=0 inst=00000013 pc=%h",
               bus.out_valid, bus.imem_en, bus.out_inst, bus.out_pc, RPC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1'b1);
    #1;
    total++;
    if (bus.imem_en !== 1'b0) begin
      bad++;
      $display("FAIL boot_no_issue: got en=%b want 0", bus.imem_en);
    end
    step();
    #1;
    total++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 14'h0) begin
      bad++;
      $display("FAIL first_issue: got en=%b addr=%h want en=1 addr=0000", bus.imem_en, bus.imem_addr);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: got v=%b want 0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin
      bad++;
      $display("FAIL first_valid: got v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, RPC);
    end
  endtask
  task test_stream();
    stream(20);
  endtask
  task test_backpressure();
    logic [13:0] want;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        #1;
        total++;
        if (bus.imem_en !== 1'b0) begin
          bad++;
          $display("FAIL stall_no_issue: got en=%b want 0", bus.imem_en);
        end
      end
      step();
    end
    want = last_acc[15:2] + 14'd2;
    total++;
    if (last_issue !== want) begin
      bad++;
      $display("FAIL stall_prefetch: got last addr %h want %h", last_issue, want);
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.imem_en !== 1'b1) begin
      bad++;
      $display("FAIL resume_issue: got en=%b want 1", bus.imem_en);
    end
    step();
    stream(10);
  endtask
  task test_redirect();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4000_0100;
    #1;
    total++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 14'h40) begin
      bad++;
      $display("FAIL redirect_issue: got en=%b addr=%h want en=1 addr=0040", bus.imem_en, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_flush: got v=%b want 0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4000_0100) begin
      bad++;
      $display("FAIL redirect_target: got v=%b pc=%h want v=1 pc=40000100", bus.out_valid, bus.out_pc);
    end
    stream(6);
  endtask
  task test_back_to_back();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4000_0200;
    step();
    bus.redirect_pc = 32'h4000_0302;
    #1;
    total++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 14'hC0) begin
      bad++;
      $display("FAIL b2b_issue: got en=%b addr=%h want en=1 addr=00c0", bus.imem_en, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flush: got v=%b want 0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4000_0300) begin
      bad++;
      $display("FAIL b2b_target: got v=%b pc=%h want v=1 pc=40000300", bus.out_valid, bus.out_pc);
    end
    stream(8);
  endtask
  task test_reset_mid();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== RPC || bus.imem_en !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b pc=%h en=%b want v=0 pc=%h en=0",
               bus.out_valid, bus.out_pc, bus.imem_en, RPC);
    end
    #2;
    rst_n = 1'b1;
    model_reset(1'b0);
    @(negedge clk);
    #1;
    total++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== 14'h0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: got en=%b addr=%h v=%b want en=1 addr=0000 v=0",
               bus.imem_en, bus.imem_addr, bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_stale: got v=%b want 0", bus.out_valid);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC) begin
      bad++;
      $display("FAIL midreset_first: got v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, RPC);
    end
    stream(10);
  endtask
  task test_random();
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.redirect_valid = $urandom_range(0, 9) == 0;
      bus.redirect_pc = RPC + 32'($urandom_range(0, 16383));
      step();
    end
    stream(6);
  endtask
  task test_perf();
`ifdef FETCH_PERF_EN
    total++;
    if (perf_fetch_cnt !== 32'(m_pops) || perf_redirect_cnt !== 32'(m_redir) || perf_stall_cnt !== 32'(m_stall)) begin
      bad++;
      $display("FAIL perf_counters: got f=%0d r=%0d s=%0d want f=%0d r=%0d s=%0d",
               perf_fetch_cnt, perf_redirect_cnt, perf_stall_cnt, m_pops, m_redir, m_stall);
    end
`endif
  endtask
  initial begin
    salt = $urandom & 32'hFFFF_0000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
